mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer for the single shared memory port (16K-word RAM + MMIO
//  window at addr[14]=1, seg-display reg / key reg). Port A = CPU data side, port B = loader/DMA.
//  Per-port 4-phase req/ack handshake; one transaction in flight; round-robin or fixed priority.
//  Sequences RAM read latency and returns read data with a one-cycle ack pulse.
// PARAMETERS
//  ADDR_W     15  memory port address width
//  DATA_W     16  data width
//  RD_LAT      1  cycles from issue to valid mem_out (1..3); writes ignore it
//  PRIO_FIXED  0  0 = round-robin between A/B; 1 = A always wins a tie
// PORTS
//  clk        in   1       system clock, all state on posedge
//  rst        in   1       asynchronous, active-low reset (asserted when 0)
//  req_a      in   1       port A request; held until ack_a
//  we_a       in   1       port A write(1)/read(0), stable while req_a
//  addr_a     in   ADDR_W  port A address, stable while req_a
//  wdata_a    in   DATA_W  port A write data, stable while req_a
//  ack_a      out  1       one-cycle completion pulse for port A
//  rdata_a    out  DATA_W  port A read data, valid when ack_a=1, held until next A read
//  req_b/we_b/addr_b/wdata_b/ack_b/rdata_b    same as port A, for port B
//  busy       out  1       transaction in flight (state != IDLE)
//  mem_addr   out  ADDR_W  to memory addr
//  mem_in     out  DATA_W  to memory in
//  mem_wEna   out  1       to memory wEna; high exactly one cycle per write
//  mem_out    in   DATA_W  from memory out
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; ack_*,busy,mem_wEna=0; mem_addr,mem_in,rdata_*=0;
//   armed_a=armed_b=1; last-served pointer = B (so A wins first tie).
//  armed_x: cleared on the cycle ack_x pulses; set when req_x sampled 0. Port x eligible
//   only if req_x & armed_x (enforces req drop between transactions; no double-serve).
//  FSM (registered outputs):
//   IDLE : if no eligible port stay. Else pick: one eligible -> it; both -> PRIO_FIXED ? A :
//          port not last served. Latch we/addr/wdata of winner, sel<=winner -> ISSUE.
//   ISSUE: mem_addr/mem_in drive latched values; mem_wEna=latched we. Write -> ACK.
//          Read -> WAIT with cnt<=RD_LAT-1 (RD_LAT=1 goes straight to WAIT with cnt=0).
//   WAIT : mem_addr held; cnt==0 -> capture mem_out into rdata_sel, -> ACK; else cnt--.
//   ACK  : ack_sel=1 for this cycle only; last-served<=sel; armed_sel<=0 -> IDLE.
//  Latency (req seen in IDLE at cycle 0): write ack at cycle 2; read ack at cycle 2+RD_LAT.
//  Throughput: same port max one transaction per 4 cycles (req must drop); alternating
//   ports back-to-back with one IDLE cycle between transactions.
//  mem_addr/mem_in hold last issued values outside ISSUE/WAIT; mem_wEna 0 outside ISSUE.
//  Requests arriving during ISSUE/WAIT/ACK are not lost: evaluated in next IDLE.
//  req withdrawn before grant: ignored (no ack). req dropped after grant: transaction
//   completes and ack still pulses (protocol violation, not error).
//  Address map is pass-through; MMIO vs RAM decode stays in the memory block.
//  Reset mid-transaction: abort immediately, no ack, no further mem_wEna; a write
//   already issued in ISSUE is not undone.
//  rdata of the port not served is never modified.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/ISSUE/WAIT/ACK), PORT_A/PORT_B ids,
//   MMIO_BIT=14 address-map constant.
//  One sub-module: rr_pick2 (combinational 2-way picker: eligible[1:0], last, fixed -> sel,
//   valid). Everything else in this module.
// TESTING
//  1 Reset then A read 0x0010 (RAM=0x1234), RD_LAT=1 -> ack_a at cycle 3, rdata_a=0x1234,
//    mem_wEna never high, busy high cycles 1-3.
//  2 B write 0x4000<-0x00AB -> mem_wEna=1 exactly one cycle (cycle 1) with mem_addr=0x4000,
//    mem_in=0x00AB; ack_b at cycle 2.
//  3 req_a,req_b both held continuously, PRIO_FIXED=0 -> grants A,B,A,B...; with
//    PRIO_FIXED=1 and A re-requesting only after 1 low cycle, B still served once per A gap.
//  4 A holds req_a high after ack_a -> no second A transaction until req_a sampled low.
//  5 rst=0 asserted during WAIT of a B read -> busy/ack/mem_wEna 0 same cycle, state IDLE,
//    no ack_b after release; next A request served normally.
//  6 RD_LAT=3 read -> ack at cycle 5; rdata equals mem_out sampled in last WAIT cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, port ids and
// the address-map constant that splits RAM from the MMIO window.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  // Address bit that selects the MMIO window (seg-display / key registers).
  localparam int MMIO_BIT = 14;

  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[MMIO_BIT];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One requester port of the shared memory arbiter: 4-phase req/ack plus the
// transaction payload and returned read data.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way picker: a lone eligible port wins; on a tie either port A
// wins outright (fixed) or the port that was not served last wins.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] eligible,
  input  port_t      last,
  input  logic       fixed,
  output port_t      sel,
  output logic       valid
);

  always_comb begin
    valid = |eligible;
    sel   = PORT_A;
    unique case (eligible)
      2'b01:   sel = PORT_A;
      2'b10:   sel = PORT_B;
      2'b11:   sel = fixed ? PORT_A : ((last == PORT_A) ? PORT_B : PORT_A);
      default: sel = PORT_A;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single shared memory port: two req/ack requesters,
// one transaction in flight, read latency sequencing and one-cycle ack pulses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int PRIO_FIXED = 0
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   port_a,
  mem_port_arbiter_if.slave   port_b,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_in,
  output logic                mem_wEna,
  input  logic [DATA_W-1:0]   mem_out
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t            state, state_d;
  port_t             sel, sel_d;
  port_t             last, last_d;
  logic              we_q, we_d;
  logic [1:0]        cnt, cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] in_d;
  logic              wena_d;
  logic              busy_d;
  logic              ack_a, ack_a_d, ack_b, ack_b_d;
  logic              armed_a, armed_a_d, armed_b, armed_b_d;
  logic [DATA_W-1:0] rdata_a, rdata_a_d, rdata_b, rdata_b_d;

  logic [1:0]        eligible;
  port_t             pick_sel;
  logic              pick_valid;

  // A port must be seen with req low before it may be served again.
  assign eligible = {port_b.req & armed_b, port_a.req & armed_a};

  rr_pick2 u_pick (
    .eligible (eligible),
    .last     (last),
    .fixed    (PRIO_FIXED != 0),
    .sel      (pick_sel),
    .valid    (pick_valid)
  );

  assign armed_a_d = ack_a ? 1'b0 : (port_a.req ? armed_a : 1'b1);
  assign armed_b_d = ack_b ? 1'b0 : (port_b.req ? armed_b : 1'b1);

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    sel_d     = sel;
    last_d    = last;
    we_d      = we_q;
    cnt_d     = cnt;
    addr_d    = mem_addr;
    in_d      = mem_in;
    wena_d    = 1'b0;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    rdata_a_d = rdata_a;
    rdata_b_d = rdata_b;

    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ISSUE;
          sel_d   = pick_sel;
          if (pick_sel == PORT_A) begin
            we_d   = port_a.we;
            addr_d = port_a.addr;
            in_d   = port_a.wdata;
            wena_d = port_a.we;
          end else begin
            we_d   = port_b.we;
            addr_d = port_b.addr;
            in_d   = port_b.wdata;
            wena_d = port_b.we;
          end
        end
      end

      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_ACK;
          ack_a_d = (sel == PORT_A);
          ack_b_d = (sel == PORT_B);
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end
      end

      ST_WAIT: begin
        if (cnt == 2'd0) begin
          state_d = ST_ACK;
          ack_a_d = (sel == PORT_A);
          ack_b_d = (sel == PORT_B);
          if (sel == PORT_A) rdata_a_d = mem_out;
          else               rdata_b_d = mem_out;
        end else begin
          cnt_d = cnt - 2'd1;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
        last_d  = sel;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      sel      <= PORT_A;
      last     <= PORT_B;
      we_q     <= 1'b0;
      cnt      <= 2'd0;
      mem_addr <= '0;
      mem_in   <= '0;
      mem_wEna <= 1'b0;
      busy     <= 1'b0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      armed_a  <= 1'b1;
      armed_b  <= 1'b1;
      rdata_a  <= '0;
      rdata_b  <= '0;
    end else begin
      state    <= state_d;
      sel      <= sel_d;
      last     <= last_d;
      we_q     <= we_d;
      cnt      <= cnt_d;
      mem_addr <= addr_d;
      mem_in   <= in_d;
      mem_wEna <= wena_d;
      busy     <= busy_d;
      ack_a    <= ack_a_d;
      ack_b    <= ack_b_d;
      armed_a  <= armed_a_d;
      armed_b  <= armed_b_d;
      rdata_a  <= rdata_a_d;
      rdata_b  <= rdata_b_d;
    end
  end

  assign port_a.ack   = ack_a;
  assign port_a.rdata = rdata_a;
  assign port_b.ack   = ack_b;
  assign port_b.rdata = rdata_b;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: round-robin/RD_LAT=1 main instance, a
// fixed-priority instance and an RD_LAT=3 instance driven side by side.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 15;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) pa(), pb(), fa(), fb(), la(), lb();

  logic          busy, busy_f, busy_l;
  logic [AW-1:0] mem_addr, mem_addr_f, mem_addr_l;
  logic [DW-1:0] mem_in, mem_in_f, mem_in_l;
  logic          mem_wEna, mem_wEna_f, mem_wEna_l;
  logic [DW-1:0] mem_out, mem_out_f, mem_out_l;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .PRIO_FIXED(0)) dut (
    .clk(clk), .rst(rst), .port_a(pa), .port_b(pb), .busy(busy),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_wEna(mem_wEna), .mem_out(mem_out));

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .PRIO_FIXED(1)) dut_f (
    .clk(clk), .rst(rst), .port_a(fa), .port_b(fb), .busy(busy_f),
    .mem_addr(mem_addr_f), .mem_in(mem_in_f), .mem_wEna(mem_wEna_f), .mem_out(mem_out_f));

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .PRIO_FIXED(0)) dut_l (
    .clk(clk), .rst(rst), .port_a(la), .port_b(lb), .busy(busy_l),
    .mem_addr(mem_addr_l), .mem_in(mem_in_l), .mem_wEna(mem_wEna_l), .mem_out(mem_out_l));

  // Memory model for the main instance: fixed RAM words, MMIO seg register, 1-cycle read.
  logic [DW-1:0] seg_reg = '0;
  int            wen_cnt = 0;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    case (a)
      15'h0010: return 16'h1234;
      15'h0011: return 16'h5A5A;
      default:  return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_wEna) begin
      wen_cnt <= wen_cnt + 1;
      if (is_mmio(32'(mem_addr))) seg_reg <= mem_in;
    end
    mem_out <= is_mmio(32'(mem_addr)) ? seg_reg : ram_word(mem_addr);
  end

  assign mem_out_f = 16'h0000;
  // A distinct value every cycle shows exactly which WAIT cycle got captured.
  assign mem_out_l = 16'hC000 | {4'h0, cyc[11:0]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Requester agent: after an ack, hold req one more cycle, drop it one cycle, re-raise.
  task automatic agent(input logic ack, inout int cool, output logic req);
    if (ack) begin
      cool = 2; req = 1'b1;
    end else if (cool == 2) begin
      cool = 1; req = 1'b0;
    end else begin
      cool = 0; req = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    port_t gm[16];
    port_t gf[16];
    int    ng_m, ng_f;
    int    cool_ma, cool_mb, cool_fa, cool_fb;
    int    c0_cyc;
    logic [DW-1:0] exp_l;

    rst = 1'b0;
    pa.req = 0; pa.we = 0; pa.addr = '0; pa.wdata = '0;
    pb.req = 0; pb.we = 0; pb.addr = '0; pb.wdata = '0;
    fa.req = 0; fa.we = 0; fa.addr = '0; fa.wdata = '0;
    fb.req = 0; fb.we = 0; fb.addr = '0; fb.wdata = '0;
    la.req = 0; la.we = 0; la.addr = '0; la.wdata = '0;
    lb.req = 0; lb.we = 0; lb.addr = '0; lb.wdata = '0;
    tick(3);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_ack_a", pa.ack, 0);
    check("rst_ack_b", pb.ack, 0);
    check("rst_wena", mem_wEna, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_in", mem_in, 0);
    check("rst_rdata_a", pa.rdata, 0);
    check("rst_rdata_b", pb.rdata, 0);
    @(negedge clk) rst = 1'b1;
    tick();

    // 1: A read 0x0010, ack at cycle 3
    pa.we = 0; pa.addr = 15'h0010; pa.req = 1;
    check("t1_c0_busy", busy, 0);
    tick();
    check("t1_c1_busy", busy, 1);
    check("t1_c1_addr", mem_addr, 15'h0010);
    check("t1_c1_wena", mem_wEna, 0);
    tick();
    check("t1_c2_busy", busy, 1);
    check("t1_c2_ack", pa.ack, 0);
    tick();
    check("t1_c3_ack", pa.ack, 1);
    check("t1_c3_rdata", pa.rdata, 16'h1234);
    check("t1_c3_busy", busy, 1);

    // 4: req_a stays high after ack -> no second transaction
    tick();
    check("t4_c4_ack", pa.ack, 0);
    check("t4_c4_busy", busy, 0);
    tick(3);
    check("t4_c7_busy", busy, 0);
    check("t4_c7_ack", pa.ack, 0);
    pa.req = 0;
    tick();
    pa.addr = 15'h0011; pa.req = 1;
    tick(3);
    check("t4_rearm_ack", pa.ack, 1);
    check("t4_rearm_rdata", pa.rdata, 16'h5A5A);
    check("t4_rdata_b_untouched", pb.rdata, 0);
    pa.req = 0;
    tick();
    check("t1_no_write", wen_cnt, 0);

    // 2: B write 0x4000 <- 0x00AB; A raises and withdraws req while B is in flight
    tick();
    pb.we = 1; pb.addr = 15'h4000; pb.wdata = 16'h00AB; pb.req = 1;
    check("t2_c0_wena", mem_wEna, 0);
    tick();
    check("t2_c1_wena", mem_wEna, 1);
    check("t2_c1_addr", mem_addr, 15'h4000);
    check("t2_c1_in", mem_in, 16'h00AB);
    pa.addr = 15'h0010; pa.req = 1;
    tick();
    check("t2_c2_wena", mem_wEna, 0);
    check("t2_c2_ack", pb.ack, 1);
    pb.req = 0; pa.req = 0;
    tick();
    check("t2_c3_ack", pb.ack, 0);
    check("t2_c3_busy", busy, 0);
    check("t2_hold_addr", mem_addr, 15'h4000);
    check("t2_hold_in", mem_in, 16'h00AB);
    check("t2_rdata_b", pb.rdata, 0);
    tick(3);
    check("t2_withdrawn_busy", busy, 0);
    check("t2_withdrawn_ack", pa.ack, 0);
    check("t2_seg_reg", seg_reg, 16'h00AB);
    check("t2_wena_count", wen_cnt, 1);

    // 5: reset during WAIT of a B read
    pb.we = 0; pb.addr = 15'h0010; pb.req = 1;
    tick();
    check("t5_c1_busy", busy, 1);
    tick();
    rst = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ack", pb.ack, 0);
    check("t5_rst_wena", mem_wEna, 0);
    check("t5_rst_addr", mem_addr, 0);
    pb.req = 0;
    @(negedge clk) rst = 1'b1;
    tick(4);
    check("t5_after_ack_b", pb.ack, 0);
    check("t5_after_busy", busy, 0);
    check("t5_after_rdata_b", pb.rdata, 0);
    pa.we = 0; pa.addr = 15'h0010; pa.req = 1;
    tick(3);
    check("t5_a_ack", pa.ack, 1);
    check("t5_a_rdata", pa.rdata, 16'h1234);
    pa.req = 0;
    tick(2);

    // Fixed-priority instance: serve A alone so its last-served pointer is A
    fa.we = 0; fa.addr = 15'h0010; fa.req = 1;
    tick(3);
    check("f_pre_ack", fa.ack, 1);
    fa.req = 0;
    tick(2);

    // 3: both ports requesting continuously on both instances (both last-served = A)
    pa.addr = 15'h0010; pb.addr = 15'h0011; pb.we = 0;
    pa.req = 1; pb.req = 1; fa.req = 1; fb.req = 1;
    ng_m = 0; ng_f = 0;
    cool_ma = 0; cool_mb = 0; cool_fa = 0; cool_fb = 0;
    for (int i = 0; i < 34; i++) begin
      tick();
      check("t3_m_single_ack", pa.ack & pb.ack, 0);
      check("t3_f_single_ack", fa.ack & fb.ack, 0);
      if (pa.ack && ng_m < 16) gm[ng_m++] = PORT_A;
      if (pb.ack && ng_m < 16) gm[ng_m++] = PORT_B;
      if (fa.ack && ng_f < 16) gf[ng_f++] = PORT_A;
      if (fb.ack && ng_f < 16) gf[ng_f++] = PORT_B;
      agent(pa.ack, cool_ma, pa.req);
      agent(pb.ack, cool_mb, pb.req);
      agent(fa.ack, cool_fa, fa.req);
      agent(fb.ack, cool_fb, fb.req);
    end
    check("t3_m_grant_count", ng_m, 8);
    check("t3_f_grant_count", ng_f, 8);
    for (int k = 0; k < 8; k++) begin
      if (k < ng_m) check($sformatf("t3_m_grant%0d", k), gm[k], (k % 2 == 0) ? PORT_B : PORT_A);
      if (k < ng_f) check($sformatf("t3_f_grant%0d", k), gf[k], (k % 2 == 0) ? PORT_A : PORT_B);
    end
    pa.req = 0; pb.req = 0; fa.req = 0; fb.req = 0;
    tick(3);

    // 6: RD_LAT=3 read, ack at cycle 5 with mem_out from cycle 4
    la.we = 0; la.addr = 15'h0020; la.req = 1;
    c0_cyc = cyc;
    exp_l = 16'hC000 | {4'h0, 12'(c0_cyc + 4)};
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("t6_c%0d_ack", k), la.ack, 0);
    end
    check("t6_c4_busy", busy_l, 1);
    tick();
    check("t6_c5_ack", la.ack, 1);
    check("t6_rdata", la.rdata, exp_l);
    check("t6_c5_busy", busy_l, 1);
    la.req = 0;
    tick();
    check("t6_c6_busy", busy_l, 0);
    check("t6_c6_ack", la.ack, 0);
    check("t6_no_write", mem_wEna_l, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
